// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point operand sequencers.
package fp_pkg;

    localparam int unsigned FP_DATA_WIDTH         = 32;
    localparam int unsigned FP_EXP_WIDTH          = 8;
    localparam int unsigned FP_SIGNIFICANDS_WIDTH = 23;

    localparam int unsigned FLAG_WIDTH = 3;
    localparam int unsigned FLAG_NAN   = 2;
    localparam int unsigned FLAG_INF   = 1;
    localparam int unsigned FLAG_ZERO  = 0;

    typedef enum logic [1:0] {
        S_A,
        S_B,
        S_SETTLE,
        S_OUT
    } state_t;

endpackage

// File: rtl/fp_add_seq_if.sv
// Operand stream in, classified result stream out; valid/ready on both sides.
interface fp_add_seq_if
    import fp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [FLAG_WIDTH-1:0] out_flags;

    modport master (
        output in_valid, in_data, in_sub, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, in_sub, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );

endinterface

// File: rtl/fp_classify.sv
// Classifies an IEEE-754 word as {nan, inf, zero}; at most one bit is set.
module fp_classify
    import fp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned EXP_WIDTH          = 8,
    parameter int unsigned SIGNIFICANDS_WIDTH = 23
) (
    input  logic [DATA_WIDTH-1:0] word,
    output logic [FLAG_WIDTH-1:0] flags
);

    logic [EXP_WIDTH-1:0]          exp_f;
    logic [SIGNIFICANDS_WIDTH-1:0] frac_f;

    assign exp_f  = word[DATA_WIDTH-2 -: EXP_WIDTH];
    assign frac_f = word[SIGNIFICANDS_WIDTH-1:0];

    always_comb begin
        flags            = '0;
        flags[FLAG_NAN]  = (&exp_f) && (|frac_f);
        flags[FLAG_INF]  = (&exp_f) && !(|frac_f);
        flags[FLAG_ZERO] = !(|exp_f) && !(|frac_f);
    end

endmodule

// File: rtl/fp_add_seq.sv
// Pairs operand words A/B for an external adder, waits a settle time, then
// captures and classifies the sum and holds it under downstream backpressure.
module fp_add_seq
    import fp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned EXP_WIDTH          = 8,
    parameter int unsigned SIGNIFICANDS_WIDTH = 23,
    parameter int unsigned SETTLE_CYCLES      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_add_seq_if.slave           bus,
    output logic [DATA_WIDTH-1:0] add_input_01,
    output logic [DATA_WIDTH-1:0] add_input_02,
    input  logic [DATA_WIDTH-1:0] add_result
);

    localparam int unsigned CNT_W = 4;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [FLAG_WIDTH-1:0] out_flags_q;
    logic [FLAG_WIDTH-1:0] flags_now;

    fp_classify #(
        .DATA_WIDTH        (DATA_WIDTH),
        .EXP_WIDTH         (EXP_WIDTH),
        .SIGNIFICANDS_WIDTH(SIGNIFICANDS_WIDTH)
    ) u_classify (
        .word (add_result),
        .flags(flags_now)
    );

    // in_ready depends on state only, so out_ready never reaches it combinationally
    assign bus.in_ready  = (state == S_A) || (state == S_B);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_A;
            cnt          <= '0;
            add_input_01 <= '0;
            add_input_02 <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_flags_q  <= '0;
        end else begin
            case (state)
                S_A: begin
                    if (bus.in_valid) begin
                        add_input_01 <= bus.in_data;
                        state        <= S_B;
                    end
                end
                S_B: begin
                    if (bus.in_valid) begin
                        add_input_02 <= {bus.in_data[DATA_WIDTH-1] ^ bus.in_sub,
                                         bus.in_data[DATA_WIDTH-2:0]};
                        cnt          <= CNT_W'(SETTLE_CYCLES - 1);
                        state        <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        out_data_q  <= add_result;
                        out_flags_q <= flags_now;
                        out_valid_q <= 1'b1;
                        state       <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_A;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_seq.sv
// Bench for fp_add_seq: table of adder vectors on two settle settings plus
// timing, backpressure and mid-settle reset sequences.
module tb_fp_add_seq;
    import fp_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] b_adj;
        logic [31:0] sum;
        logic [2:0]  flags;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  flags;
        logic [31:0] b_adj;
    } exp_t;

    localparam int NV = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_t vt [NV];
    exp_t q1 [$];
    exp_t q3 [$];
    int   total = 0;
    int   bad   = 0;

    logic [31:0] a1_in1, a1_in2, a1_res;
    logic [31:0] a3_in1, a3_in2, a3_res;

    fp_add_seq_if #(.DATA_WIDTH(32)) bus1 ();
    fp_add_seq_if #(.DATA_WIDTH(32)) bus3 ();

    fp_add_seq #(
        .DATA_WIDTH(32), .EXP_WIDTH(8), .SIGNIFICANDS_WIDTH(23), .SETTLE_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .add_input_01(a1_in1), .add_input_02(a1_in2), .add_result(a1_res)
    );

    fp_add_seq #(
        .DATA_WIDTH(32), .EXP_WIDTH(8), .SIGNIFICANDS_WIDTH(23), .SETTLE_CYCLES(3)
    ) dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .add_input_01(a3_in1), .add_input_02(a3_in2), .add_result(a3_res)
    );

    // Adder stand-in: known operand pairs give their true sum, anything else a marker.
    function automatic logic [31:0] adder_model(input logic [31:0] x, input logic [31:0] y);
        for (int i = 0; i < NV; i++)
            if (vt[i].a == x && vt[i].b_adj == y) return vt[i].sum;
        return 32'hDEAD_BEEF;
    endfunction

    assign a1_res = adder_model(a1_in1, a1_in2);
    assign a3_res = adder_model(a3_in1, a3_in2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 1) ? bus1.in_ready : bus3.in_ready;
    endfunction

    function automatic logic get_ovalid(input int sel);
        return (sel == 1) ? bus1.out_valid : bus3.out_valid;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [31:0] d, input logic s);
        if (sel == 1) begin
            bus1.in_valid = v; bus1.in_data = d; bus1.in_sub = s;
        end else begin
            bus3.in_valid = v; bus3.in_data = d; bus3.in_sub = s;
        end
    endtask

    task automatic check_out(input int sel);
        exp_t        e;
        logic [31:0] d, ai2;
        logic [2:0]  f;
        int          qs;
        d   = (sel == 1) ? bus1.out_data  : bus3.out_data;
        f   = (sel == 1) ? bus1.out_flags : bus3.out_flags;
        ai2 = (sel == 1) ? a1_in2 : a3_in2;
        qs  = (sel == 1) ? q1.size() : q3.size();
        total++;
        if (qs == 0) begin
            bad++;
            $display("FAIL unexpected_out dut%0d: got %h expected none", sel, d);
            return;
        end
        e = (sel == 1) ? q1.pop_front() : q3.pop_front();
        if (d !== e.data || f !== e.flags || ai2 !== e.b_adj) begin
            bad++;
            $display("FAIL out dut%0d: got data=%h flags=%b b=%h expected data=%h flags=%b b=%h",
                     sel, d, f, ai2, e.data, e.flags, e.b_adj);
        end
    endtask

    always @(negedge clk) if (!rst && bus1.out_valid && bus1.out_ready) check_out(1);
    always @(negedge clk) if (!rst && bus3.out_valid && bus3.out_ready) check_out(3);

    // Offers a word from the negedge, returns #1 after the accepting edge.
    task automatic drive_word(input int sel, input logic [31:0] d, input logic s);
        int n = 0;
        @(negedge clk);
        set_in(sel, 1'b1, d, s);
        while (!get_ready(sel) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL in_ready_timeout dut%0d: got 0 expected 1", sel);
        end
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic push_exp(input int sel, input int i);
        exp_t e;
        e.data = vt[i].sum; e.flags = vt[i].flags; e.b_adj = vt[i].b_adj;
        if (sel == 1) q1.push_back(e); else q3.push_back(e);
    endtask

    task automatic send_pair(input int sel, input int i);
        push_exp(sel, i);
        drive_word(sel, vt[i].a, 1'($urandom_range(0, 1)));
        drive_word(sel, vt[i].b, vt[i].sub);
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q1.size(), q3.size());
        end
        repeat (2) @(posedge clk);
    endtask

    // Checks out_valid rises exactly SETTLE edges after the B handshake, inputs held.
    task automatic timing_seq(input int sel, input int settle, input int i);
        logic [31:0] i1, i2;
        push_exp(sel, i);
        drive_word(sel, vt[i].a, 1'b0);
        drive_word(sel, vt[i].b, vt[i].sub);
        i1 = (sel == 1) ? a1_in1 : a3_in1;
        i2 = (sel == 1) ? a1_in2 : a3_in2;
        check("b_adj_loaded", i2, vt[i].b_adj);
        check("settle_in_ready", 32'(get_ready(sel)), 32'd0);
        check("settle_out_valid0", 32'(get_ovalid(sel)), 32'd0);
        for (int n = 1; n <= settle; n++) begin
            @(posedge clk);
            #1;
            check("settle_in1_hold", (sel == 1) ? a1_in1 : a3_in1, i1);
            check("settle_in2_hold", (sel == 1) ? a1_in2 : a3_in2, i2);
            check("out_valid_edge", 32'(get_ovalid(sel)), (n == settle) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic [31:0] hd;
        logic [2:0]  hf;
        int          n;

        vt[0] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000, 3'b000};
        vt[1] = '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'hBFC00000, 32'h00000000, 3'b001};
        vt[2] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h3F800000, 32'h7F800000, 3'b010};
        vt[3] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h3F800000, 32'h7FC00000, 3'b100};
        vt[4] = '{32'h40400000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h40000000, 3'b000};
        vt[5] = '{32'hC0000000, 32'hC0000000, 1'b0, 32'hC0000000, 32'hC0800000, 3'b000};
        vt[6] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 32'h80000000, 3'b001};
        vt[7] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'hFF800000, 32'h7FC00000, 3'b100};

        set_in(1, 1'b0, 32'h0, 1'b0);
        set_in(3, 1'b0, 32'h0, 1'b0);
        bus1.out_ready = 1'b1;
        bus3.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus1.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        check("rst_in1", a1_in1, 32'h0);
        check("rst_in2", a1_in2, 32'h0);
        check("rst_out_data", bus1.out_data, 32'h0);
        check("rst_out_flags", 32'(bus1.out_flags), 32'd0);
        check("rst_in_ready3", 32'(bus3.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        timing_seq(1, 1, 0);
        timing_seq(3, 3, 0);
        drain();

        for (int i = 0; i < NV; i++) send_pair(1, i);
        for (int i = 0; i < NV; i++) send_pair(3, i);
        drain();

        // Backpressure on dut1, with the next A already offered.
        @(negedge clk);
        bus1.out_ready = 1'b0;
        push_exp(1, 2);
        drive_word(1, vt[2].a, 1'b0);
        drive_word(1, vt[2].b, vt[2].sub);
        n = 0;
        while (!bus1.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("bp_out_valid_rise", 32'(bus1.out_valid), 32'd1);
        hd = bus1.out_data;
        hf = bus1.out_flags;
        check("bp_data", hd, 32'h7F800000);
        check("bp_flags", 32'(hf), 32'(3'b010));
        push_exp(1, 4);
        set_in(1, 1'b1, vt[4].a, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_data_hold", bus1.out_data, hd);
            check("bp_flags_hold", 32'(bus1.out_flags), 32'(hf));
            check("bp_in_ready", 32'(bus1.in_ready), 32'd0);
            check("bp_in1_hold", a1_in1, vt[2].a);
        end
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", 32'(bus1.in_ready), 32'd1);
        check("bp_release_valid", 32'(bus1.out_valid), 32'd0);
        check("bp_a_not_yet", a1_in1, vt[2].a);
        @(posedge clk); #1;
        check("bp_a_taken", a1_in1, vt[4].a);
        set_in(1, 1'b0, 32'h0, 1'b0);
        drive_word(1, vt[4].b, vt[4].sub);
        drain();

        // Reset in the middle of dut3 settling: the pair is dropped.
        drive_word(3, vt[5].a, 1'b0);
        drive_word(3, vt[5].b, vt[5].sub);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check("mid_rst_out_valid", 32'(bus3.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus3.in_ready), 32'd1);
        check("mid_rst_in1", a3_in1, 32'h0);
        check("mid_rst_in2", a3_in2, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", 32'(bus3.out_valid), 32'd0);
        end
        send_pair(3, 1);
        drain();

        check("q1_left", 32'(q1.size()), 32'd0);
        check("q3_left", 32'(q3.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
